// File: rtl/fifo_converter_64to32b_if.sv
// MEMFIFO read side and OUTFIFO write side of the 64-to-32 bit converter.
// The converter uses the master modport; the FIFOs (or a bench) use the slave modport.
interface fifo_converter_64to32b_if;
  localparam int unsigned MEM_W = 64;
  localparam int unsigned OUT_W = 32;

  logic             memfifo_empty;
  logic [MEM_W-1:0] memfifo_64bit;
  logic             memfifo_re;
  logic             outfifo_full;
  logic             outfifo_we;
  logic [OUT_W-1:0] outfifo_32bit;

  modport master (
    input  memfifo_empty, memfifo_64bit, outfifo_full,
    output memfifo_re, outfifo_we, outfifo_32bit
  );

  modport slave (
    output memfifo_empty, memfifo_64bit, outfifo_full,
    input  memfifo_re, outfifo_we, outfifo_32bit
  );
endinterface

// File: rtl/fifo_converter_64to32b.sv
// Pops 64-bit words from the FWFT memory-readback FIFO and writes each word
// as two 32-bit halves into OUTFIFO, for a programmed number of words.
module fifo_converter_64to32b #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter bit          HIGH_FIRST = 1'b0
) (
  input  logic                 digiclk_i,
  input  logic                 resetn_i,
  input  logic                 fifo_read_mem_en,
  input  logic [CNT_WIDTH-1:0] xfer_len,
  input  logic                 abort,
  fifo_converter_64to32b_if.master bus,
  output logic                 busy,
  output logic                 xfer_done
);
  localparam int unsigned MEM_W = 64;
  localparam int unsigned OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [MEM_W-1:0]     hold_q, hold_d;
  logic [OUT_W-1:0]     data_q, data_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [OUT_W-1:0]     first_half, second_half;

  // Half ordering: first half comes straight off the FIFO head, second from the held word.
  assign first_half  = HIGH_FIRST ? bus.memfifo_64bit[63:32] : bus.memfifo_64bit[31:0];
  assign second_half = HIGH_FIRST ? hold_q[31:0] : hold_q[63:32];

  always_ff @(posedge digiclk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      hold_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    hold_d         = hold_q;
    data_d         = data_q;
    we_d           = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    bus.memfifo_re = 1'b0;

    // Abort outranks everything outside IDLE; any held half-word is dropped.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_read_mem_en && !abort) begin
            if (xfer_len != '0) begin
              remaining_d = xfer_len;
              busy_d      = 1'b1;
              state_d     = FETCH;
            end else begin
              state_d = DONE;
            end
          end
        end
        FETCH: begin
          // Almost-full guarantees room for both halves once the pop is taken.
          if (!bus.memfifo_empty && !bus.outfifo_full) begin
            bus.memfifo_re = 1'b1;
            hold_d         = bus.memfifo_64bit;
            data_d         = first_half;
            we_d           = 1'b1;
            state_d        = SECOND;
          end
        end
        SECOND: begin
          if (!bus.outfifo_full) begin
            data_d = second_half;
            we_d   = 1'b1;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - CNT_WIDTH'(1);
            end
            state_d = (remaining_q <= CNT_WIDTH'(1)) ? DONE : FETCH;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
          data_d      = '0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  assign bus.outfifo_we    = we_q;
  assign bus.outfifo_32bit = data_q;
  assign busy              = busy_q;
  assign xfer_done         = done_q;
endmodule
